// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and the scan-phase type for the 7-segment scan controller.
package seg_pkg;

  // Code sent to the shared decoder when nothing should be lit.
  localparam logic [3:0] SEG_BLANK_CODE = 4'hF;

  // Inactive level of one common-anode enable line.
  localparam logic ANODE_OFF = 1'b1;

  // Two phases inside every digit slot: anti-ghosting guard, then display.
  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of the scan controller.
// There is no valid/ready handshake here: the host side holds level signals
// (enable, digits, masks) that the controller samples on its own schedule
// (enable every clock, the rest once per frame), and the controller side drives
// registered display outputs that are meaningful on every clock.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;

  logic [3:0]              bcd_sel;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_start;

  // Host: supplies the values to display and observes the scan outputs.
  modport master (
    output enable, digits, blank_mask, blink_mask, dp_mask,
    input  bcd_sel, an, dp, digit_idx, frame_start
  );

  // Scan controller.
  modport slave (
    input  enable, digits, blank_mask, blink_mask, dp_mask,
    output bcd_sel, an, dp, digit_idx, frame_start
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits sharing
// one BCD-to-7-segment decoder. Each slot opens with a guard interval (all
// anodes off) and then lights one digit. Inputs are snapshotted once per frame.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   bus,
  output scan_state_t scan_state
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      DIV_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      GUARD_END  = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]      BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = {NUM_DIGITS{ANODE_OFF}};

  // Scan timing
  logic [CNT_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      slot_cnt;
  logic [BLK_W-1:0]      blink_cnt;
  logic                  blink_phase;
  scan_state_t           state, next_state;

  // Frame snapshot
  logic [DW-1:0]         snap_digits;
  logic [NUM_DIGITS-1:0] snap_blank;
  logic [NUM_DIGITS-1:0] snap_blink;
  logic [NUM_DIGITS-1:0] snap_dp;

  // Registered outputs and the latched "digit shown in this slot" flag
  logic [NUM_DIGITS-1:0] an_q;
  logic [3:0]            bcd_q;
  logic                  dp_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  fs_q;
  logic                  show_q;

  // Decode helpers
  logic                  slot_start, slot_wrap, frame_wrap, first_slot;
  logic [DW-1:0]         eff_digits;
  logic [NUM_DIGITS-1:0] eff_blank, eff_blink, eff_dp;
  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  slot_show;
  logic                  show_next;
  logic [NUM_DIGITS-1:0] an_next;

  // Slot/frame boundaries; on the first slot of a frame the live inputs are
  // used directly because the snapshot is being captured on that same edge.
  always_comb begin
    slot_start = (div_cnt == '0);
    slot_wrap  = (div_cnt == DIV_LAST);
    frame_wrap = slot_wrap && (slot_cnt == IDX_LAST);
    first_slot = slot_start && (slot_cnt == '0);
    eff_digits = first_slot ? bus.digits     : snap_digits;
    eff_blank  = first_slot ? bus.blank_mask : snap_blank;
    eff_blink  = first_slot ? bus.blink_mask : snap_blink;
    eff_dp     = first_slot ? bus.dp_mask    : snap_dp;
    cur_code   = eff_digits[{slot_cnt, 2'b00} +: 4];
    cur_dp     = eff_dp[slot_cnt];
    slot_show  = bus.enable && !eff_blank[slot_cnt] &&
                 !(eff_blink[slot_cnt] && blink_phase);
  end

  // Next phase of the slot: guard from slot start until GUARD_CYCLES clocks
  // have elapsed, then show until the slot ends.
  always_comb begin
    next_state = state;
    case (state)
      GUARD:   if (div_cnt == GUARD_END) next_state = SHOW;
      SHOW:    if (slot_start)           next_state = GUARD;
      default: next_state = GUARD;
    endcase
  end

  // Anode drive: a digit decided visible at slot start stays lit only while
  // enable remains high; a drop turns it off on the next clock.
  always_comb begin
    show_next = slot_start ? slot_show : (show_q && bus.enable);
    an_next   = AN_ALL_OFF;
    if (next_state == SHOW && show_next)
      an_next = ~(NUM_DIGITS'(1) << slot_cnt);
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GUARD;
    else        state <= next_state;
  end

  // Slot divider, slot index and blink timebase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      slot_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      div_cnt <= slot_wrap ? '0 : div_cnt + 1'b1;
      if (slot_wrap)
        slot_cnt <= (slot_cnt == IDX_LAST) ? '0 : slot_cnt + 1'b1;
      if (frame_wrap) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Frame snapshot of the display inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits <= '0;
      snap_blank  <= '0;
      snap_blink  <= '0;
      snap_dp     <= '0;
    end else if (first_slot) begin
      snap_digits <= bus.digits;
      snap_blank  <= bus.blank_mask;
      snap_blink  <= bus.blink_mask;
      snap_dp     <= bus.dp_mask;
    end
  end

  // Output registers; code and dp settle at slot start, ahead of the anode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q   <= AN_ALL_OFF;
      bcd_q  <= SEG_BLANK_CODE;
      dp_q   <= 1'b1;
      idx_q  <= '0;
      fs_q   <= 1'b0;
      show_q <= 1'b0;
    end else begin
      an_q   <= an_next;
      show_q <= show_next;
      fs_q   <= first_slot;
      if (slot_start) begin
        bcd_q <= slot_show ? cur_code : SEG_BLANK_CODE;
        dp_q  <= slot_show ? ~cur_dp : 1'b1;
        idx_q <= slot_cnt;
      end
    end
  end

  assign bus.an          = an_q;
  assign bus.bcd_sel     = bcd_q;
  assign bus.dp          = dp_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_start = fs_q;
  assign scan_state      = state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a cycle-indexed reference model pushes the expected
// outputs for every clock into a queue; a monitor pops and compares them.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;
  localparam int BF = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();
  scan_state_t scan_state;

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD_CYCLES(GC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .scan_state(scan_state)
  );

  // Scoreboard: {an, bcd_sel, dp, digit_idx, frame_start}
  logic [11:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: output after the p-th clock since reset release,
  // derived from absolute cycle position within slot and frame.
  int          p = 0;
  logic [15:0] s_dig;
  logic [3:0]  s_blank, s_blink, s_dp;
  bit          en_ok, start_vis;
  logic [3:0]  m_bcd;
  logic        m_dp;

  initial begin
    int slot, off, frame, phase;
    logic [3:0] an_e;
    logic fs;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        p = 0;
      end else begin
        slot  = (p / RD) % ND;
        off   = p % RD;
        frame = p / (RD * ND);
        phase = (frame / BF) % 2;
        fs    = 1'b0;
        if (slot == 0 && off == 0) begin
          s_dig   = bus.digits;
          s_blank = bus.blank_mask;
          s_blink = bus.blink_mask;
          s_dp    = bus.dp_mask;
          fs      = 1'b1;
        end
        if (off == 0) begin
          en_ok     = bus.enable;
          start_vis = bus.enable && !s_blank[slot] && !(s_blink[slot] && phase == 1);
          m_bcd     = start_vis ? s_dig[slot*4 +: 4] : 4'hF;
          m_dp      = start_vis ? ~s_dp[slot] : 1'b1;
        end else begin
          en_ok = en_ok && bus.enable;
        end
        an_e = 4'b1111;
        if (off >= GC && start_vis && en_ok) an_e[slot] = 1'b0;
        exp_q.push_back({an_e, m_bcd, m_dp, 2'(slot), fs});
        p++;
      end
    end
  end

  // Monitor: one expected word per clock while out of reset.
  initial begin
    logic [11:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {bus.an, bus.bcd_sel, bus.dp, bus.digit_idx, bus.frame_start};
        n_vec++;
        if (g !== e) begin
          n_err++;
          $display("FAIL outputs t=%0t got an=%b bcd=%h dp=%b idx=%0d fs=%b, expected an=%b bcd=%h dp=%b idx=%0d fs=%b",
                   $time, g[11:8], g[7:4], g[3], g[2:1], g[0], e[11:8], e[7:4], e[3], e[2:1], e[0]);
        end
        n_vec++;
        if ($countones(~bus.an) > 1) begin
          n_err++;
          $display("FAIL one_hot_anode t=%0t got an=%b, expected at most one low bit", $time, bus.an);
        end
        if (scan_state == GUARD) begin
          n_vec++;
          if (bus.an !== 4'b1111) begin
            n_err++;
            $display("FAIL guard_dark t=%0t got an=%b, expected 1111", $time, bus.an);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_an"},    8'(bus.an), 8'hF);
    chk({tag, "_bcd"},   8'(bus.bcd_sel), 8'hF);
    chk({tag, "_dp"},    8'(bus.dp), 8'h1);
    chk({tag, "_idx"},   8'(bus.digit_idx), 8'h0);
    chk({tag, "_fs"},    8'(bus.frame_start), 8'h0);
    chk({tag, "_state"}, 8'(scan_state), 8'(GUARD));
  endtask

  task automatic set_inputs(input logic en, input logic [15:0] d, input logic [3:0] bl,
                            input logic [3:0] bk, input logic [3:0] dpm);
    bus.enable     = en;
    bus.digits     = d;
    bus.blank_mask = bl;
    bus.blink_mask = bk;
    bus.dp_mask    = dpm;
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) bus.digits = 16'($urandom);
      if ($urandom_range(0, 15) == 0) bus.blank_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.dp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) bus.enable = ~bus.enable;
    end
  endtask

  // Stimulus
  initial begin
    bit found;
    set_inputs(1'b1, 16'h1234, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset("por_async");
    repeat (5) @(negedge clk);
    check_reset("por_hold");
    rst_n = 1'b1;

    // Plain scan, then a digit change in slot 2 that must wait for the next frame.
    repeat (20) @(negedge clk);
    bus.digits = 16'h5678;
    repeat (44) @(negedge clk);

    // Blinking digit 0.
    set_inputs(1'b1, 16'h1234, 4'h0, 4'b0001, 4'h0);
    repeat (6 * RD * ND) @(negedge clk);

    // Blanked digit 3 with a pass-through code, dp on digit 2; then unblanked.
    set_inputs(1'b1, 16'hA234, 4'b1000, 4'h0, 4'b0100);
    repeat (2 * RD * ND) @(negedge clk);
    bus.blank_mask = 4'h0;
    repeat (2 * RD * ND) @(negedge clk);

    // Randomized traffic, including enable drops.
    run_random(1500);

    // Asynchronous reset in the middle of slot 1's show phase.
    set_inputs(1'b1, 16'h9876, 4'h0, 4'h0, 4'h1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.digit_idx == 2'd1 && scan_state == SHOW && bus.an == 4'b1101) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL wait_slot1_show got timeout, expected slot 1 lit within 200 clocks");
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("mid_show_async");
    repeat (3) @(negedge clk);
    check_reset("mid_show_hold");
    rst_n = 1'b1;
    repeat (3 * RD * ND) @(negedge clk);
    run_random(400);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one BCD-to-7-segment decoder across NUM_DIGITS common-anode digits on the alarm-clock display. Each cycle it selects one digit's BCD code for the shared decoder and drives the active-low anode lines. It inserts an anti-ghosting guard interval, applies per-digit blanking and blinking (used for alarm/time-set editing), and snapshots inputs once per frame so a frame never mixes old and new values.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
REFRESH_DIV, 100000, clocks per digit slot (>=4)
GUARD_CYCLES, 2000, clocks at slot start with all anodes off (1 <= GUARD_CYCLES < REFRESH_DIV)
BLINK_FRAMES, 64, frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = display on; 0 = anodes forced off, counters keep running
digits  in  4*NUM_DIGITS  BCD codes; digit i = digits[4i+3:4i], digit 0 rightmost
blank_mask  in  NUM_DIGITS  1 = digit permanently off
blink_mask  in  NUM_DIGITS  1 = digit off during the blink-off phase
dp_mask  in  NUM_DIGITS  1 = decimal point lit on that digit
bcd_sel  out  4  code to shared decoder; 4'hF when nothing is shown
an  out  NUM_DIGITS  anode enables, active-low
dp  out  1  decimal point, active-low
digit_idx  out  clog2(NUM_DIGITS)  index of the current slot
frame_start  out  1  one-cycle pulse on the first clock of slot 0

Behaviour:
- Reset (async, rst_n=0): an all 1, bcd_sel 4'hF, dp 1, digit_idx 0, frame_start 0, div_cnt 0, blink_cnt 0, blink_phase 0, snapshot regs 0, state GUARD. Outputs change immediately and independently of clk.
- All outputs are registered.
- div_cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
- FSM with two states per slot:
  - GUARD: active for div_cnt 0..GUARD_CYCLES-1; an all 1.
  - SHOW: active for the remaining slot cycles; an bit digit_idx = 0 unless suppressed.
- bcd_sel and dp are updated on the first clock of the slot, so they are stable before any anode turns on.
- Snapshot: on the first clock of slot 0 (including the first slot after reset), latch digits, blank_mask, blink_mask and dp_mask. All display decisions use the snapshot only. frame_start pulses in that same cycle.
- Blink: at each frame wrap (slot NUM_DIGITS-1 -> 0), blink_cnt increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles. The first frame after reset is phase 0 (visible).
- A digit is suppressed when any of these holds: enable=0; snapshot blank bit=1; snapshot blink bit=1 and blink_phase=1.
- Suppressed digit: bcd_sel 4'hF, dp 1, anode stays 1 for the whole slot.
- Shown digit: bcd_sel = snapshot code. Codes >9 pass through unmodified; the decoder renders them dark, but the anode still turns on.
- dp = ~snapshot dp bit when shown.
- enable is sampled every clock. Deassertion forces an all 1 on the next clock, even mid-SHOW. Reassertion takes effect at the next slot start.
- Exactly one anode may be low at any time. Anodes are never low during GUARD.

Decomposition:
- Shared package seg_pkg: constants SEG_BLANK_CODE = 4'hF and ANODE_OFF; state typedef scan_state_t {GUARD, SHOW}.
- No sub-module required. The shared decoder is instantiated by the parent: bcd_sel feeds the decoder's 4-bit input and an drives the display directly.

Test Plan:
Params for all tests: NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, BLINK_FRAMES=2, enable=1 unless stated.
1. Hold rst_n=0 for 5 clk, then release -> during reset an=4'b1111, bcd_sel=F, dp=1. After release: frame_start=1 on the first edge; an=1111 for 2 clks, then an=1110 for 6 clks.
2. digits=16'h1234, masks 0 -> over 32 clks bcd_sel sequence is 4,3,2,1 (8 clks each); an sequence per slot is 1110,1101,1011,0111 after guard; never two anode bits low.
3. Change digits from 16'h1234 to 16'h5678 during slot 2 -> slots 2-3 still show 2,1; the next frame shows 8,7,6,5.
4. blink_mask=4'b0001 -> digit 0 anode on in frames 0-1, off in frames 2-3, on in frames 4-5; other digits unaffected.
5. blank_mask=4'b1000, digits=16'hA234, dp_mask=4'b0100 -> slot 3 an stays 1111 and bcd_sel=F. Repeat with blank_mask=0: slot 3 gives an=0111, bcd_sel=A. In slot 2, dp=0.
6. Assert rst_n=0 mid-SHOW of slot 1, release 3 clks later -> an=1111 asynchronously. The scan restarts at slot 0 with guard, then a new snapshot and frame_start.
